// File: rtl/motor_ctrl_regbank_shadowed.sv
// Avalon-MM register bank for per-motor PID configuration with shadow/active
// double-buffering, atomic multi-motor COMMIT, pending tracking and error counting.
module motor_ctrl_regbank_shadowed #(
  parameter int          NUMBER_OF_MOTORS = 8,
  parameter logic [31:0] ID_VALUE         = 32'hB15B0002,
  parameter int          DEFAULT_KP       = 1,
  parameter int          DEFAULT_PWMLIMIT = 8388607,
  parameter int          DEFAULT_INTLIMIT = 500000,
  parameter int          DEFAULT_MODE     = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [15:0]                      address,
  input  logic                             write,
  input  logic [31:0]                      writedata,
  input  logic                             read,
  output logic [31:0]                      readdata,
  output logic                             waitrequest,
  input  logic [NUMBER_OF_MOTORS*24-1:0]   position_i,
  output logic [NUMBER_OF_MOTORS*16-1:0]   kp_o,
  output logic [NUMBER_OF_MOTORS*16-1:0]   ki_o,
  output logic [NUMBER_OF_MOTORS*16-1:0]   kd_o,
  output logic [NUMBER_OF_MOTORS*24-1:0]   setpoint_o,
  output logic [NUMBER_OF_MOTORS*24-1:0]   pwmlimit_o,
  output logic [NUMBER_OF_MOTORS*24-1:0]   intlimit_o,
  output logic [NUMBER_OF_MOTORS*24-1:0]   deadband_o,
  output logic [NUMBER_OF_MOTORS*8-1:0]    control_mode_o,
  output logic [31:0]                      update_frequency_Hz,
  output logic [NUMBER_OF_MOTORS-1:0]      commit_strobe_o
);

  localparam logic [7:0] R_ID = 8'h00, R_KP = 8'h01, R_KI = 8'h02, R_KD = 8'h03,
                         R_POS = 8'h04, R_PWM = 8'h08, R_INT = 8'h09, R_DB = 8'h0A,
                         R_MODE = 8'h0B, R_SP = 8'h0C, R_FREQ = 8'h11, R_ERR = 8'h1D,
                         R_PEND = 8'h1E, R_COMMIT = 8'h1F;
  localparam logic [31:0] BAD = 32'hDEADBEEF;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  typedef struct packed {
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [23:0] pwm;
    logic [23:0] intl;
    logic [23:0] db;
    logic [23:0] sp;
    logic [7:0]  mode;
  } chan_t;

  localparam chan_t CHAN_RST = '{kp: 16'(DEFAULT_KP), ki: 16'd0, kd: 16'd0,
                                 pwm: 24'(DEFAULT_PWMLIMIT), intl: 24'(DEFAULT_INTLIMIT),
                                 db: 24'd0, sp: 24'd0, mode: 8'(DEFAULT_MODE)};

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] sext24(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  chan_t                       sh_q  [NUMBER_OF_MOTORS];
  chan_t                       act_q [NUMBER_OF_MOTORS];
  logic [NUMBER_OF_MOTORS-1:0] pend_q, strobe_q;
  logic [31:0]                 freq_q, rdata_q, rdata_d;
  logic [15:0]                 err_q, err_d;
  state_t                      state_q;

  logic [7:0] reg_idx, mot;
  logic       per_motor, is_global, motor_ok, rd_legal, wr_legal;
  logic       accept, wr_en, shadow_wr, commit_en, err_inc;

  assign reg_idx = address[15:8];
  assign mot     = address[7:0];

  always_comb begin
    per_motor = reg_idx inside {R_KP, R_KI, R_KD, R_POS, R_PWM, R_INT, R_DB, R_MODE, R_SP};
    is_global = reg_idx inside {R_ID, R_FREQ, R_ERR, R_PEND, R_COMMIT};
    motor_ok  = {24'd0, mot} < 32'(NUMBER_OF_MOTORS);
    rd_legal  = is_global || (per_motor && motor_ok);
    wr_legal  = (reg_idx inside {R_FREQ, R_ERR, R_COMMIT}) ||
                (per_motor && motor_ok && reg_idx != R_POS);
  end

  // A write that collides with a read is dropped; the read wins.
  assign accept    = read && (state_q == S_IDLE);
  assign wr_en     = write && !read && wr_legal;
  assign shadow_wr = wr_en && per_motor;
  assign commit_en = wr_en && (reg_idx == R_COMMIT);
  assign err_inc   = (accept && !rd_legal) || (write && (read || !wr_legal));

  always_comb begin
    err_d = err_q;
    if (wr_en && reg_idx == R_ERR) err_d = 16'd0;
    else if (err_inc && err_q != 16'hFFFF) err_d = err_q + 16'd1;
  end

  always_comb begin
    rdata_d = BAD;
    case (reg_idx)
      R_ID:    rdata_d = ID_VALUE;
      R_FREQ:  rdata_d = freq_q;
      R_ERR:   rdata_d = {16'd0, err_q};
      R_PEND:  rdata_d = 32'(pend_q);
      default: begin
        for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
          if (per_motor && mot == 8'(m)) begin
            case (reg_idx)
              R_KP:    rdata_d = sext16(sh_q[m].kp);
              R_KI:    rdata_d = sext16(sh_q[m].ki);
              R_KD:    rdata_d = sext16(sh_q[m].kd);
              R_POS:   rdata_d = sext24(position_i[m*24 +: 24]);
              R_PWM:   rdata_d = sext24(sh_q[m].pwm);
              R_INT:   rdata_d = sext24(sh_q[m].intl);
              R_DB:    rdata_d = sext24(sh_q[m].db);
              R_SP:    rdata_d = sext24(sh_q[m].sp);
              R_MODE:  rdata_d = {24'd0, sh_q[m].mode};
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Read handshake: one wait cycle in IDLE, data presented in ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      err_q   <= 16'd0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE: if (read) begin
          rdata_q <= rdata_d;
          state_q <= S_ACK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
        sh_q[m]  <= CHAN_RST;
        act_q[m] <= CHAN_RST;
      end
      pend_q   <= '0;
      strobe_q <= '0;
      freq_q   <= 32'd100;
    end else begin
      strobe_q <= '0;
      if (wr_en && reg_idx == R_FREQ) freq_q <= writedata;
      for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
        if (shadow_wr && mot == 8'(m)) begin
          pend_q[m] <= 1'b1;
          case (reg_idx)
            R_KP:    sh_q[m].kp   <= writedata[15:0];
            R_KI:    sh_q[m].ki   <= writedata[15:0];
            R_KD:    sh_q[m].kd   <= writedata[15:0];
            R_PWM:   sh_q[m].pwm  <= writedata[23:0];
            R_INT:   sh_q[m].intl <= writedata[23:0];
            R_DB:    sh_q[m].db   <= writedata[23:0];
            R_SP:    sh_q[m].sp   <= writedata[23:0];
            R_MODE:  sh_q[m].mode <= writedata[7:0];
            default: ;
          endcase
        end
        if (commit_en && writedata[m]) begin
          act_q[m]    <= sh_q[m];
          pend_q[m]   <= 1'b0;
          strobe_q[m] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUMBER_OF_MOTORS; g++) begin : g_out
    assign kp_o[g*16 +: 16]          = act_q[g].kp;
    assign ki_o[g*16 +: 16]          = act_q[g].ki;
    assign kd_o[g*16 +: 16]          = act_q[g].kd;
    assign pwmlimit_o[g*24 +: 24]    = act_q[g].pwm;
    assign intlimit_o[g*24 +: 24]    = act_q[g].intl;
    assign deadband_o[g*24 +: 24]    = act_q[g].db;
    assign setpoint_o[g*24 +: 24]    = act_q[g].sp;
    assign control_mode_o[g*8 +: 8]  = act_q[g].mode;
  end

  assign waitrequest         = read && (state_q == S_IDLE) && !reset;
  assign readdata            = rdata_q;
  assign update_frequency_Hz = freq_q;
  assign commit_strobe_o     = strobe_q;

endmodule

// File: tb/tb_motor_ctrl_regbank_shadowed.sv
// Directed bench for motor_ctrl_regbank_shadowed with eight motor channels.
module tb_motor_ctrl_regbank_shadowed;

  localparam int NM = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [15:0]       address = '0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic              read = 1'b0;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic [NM*24-1:0]  position_i = '0;
  logic [NM*16-1:0]  kp_o, ki_o, kd_o;
  logic [NM*24-1:0]  setpoint_o, pwmlimit_o, intlimit_o, deadband_o;
  logic [NM*8-1:0]   control_mode_o;
  logic [31:0]       update_frequency_Hz;
  logic [NM-1:0]     commit_strobe_o;

  int n_chk = 0;
  int n_bad = 0;

  motor_ctrl_regbank_shadowed #(.NUMBER_OF_MOTORS(NM)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .waitrequest(waitrequest), .position_i(position_i),
    .kp_o(kp_o), .ki_o(ki_o), .kd_o(kd_o), .setpoint_o(setpoint_o), .pwmlimit_o(pwmlimit_o),
    .intlimit_o(intlimit_o), .deadband_o(deadband_o), .control_mode_o(control_mode_o),
    .update_frequency_Hz(update_frequency_Hz), .commit_strobe_o(commit_strobe_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    #1 chk("wr_wait", 192'(waitrequest), 192'(1'b0));
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input string tag, input logic [31:0] exp);
    @(negedge clk);
    address = a; read = 1'b1;
    #1 chk({tag, "_wait1"}, 192'(waitrequest), 192'(1'b1));
    @(negedge clk);
    read = 1'b0;
    #1 chk({tag, "_wait0"}, 192'(waitrequest), 192'(1'b0));
    chk(tag, 192'(readdata), 192'(exp));
  endtask

  initial begin
    int done_cnt;
    repeat (3) @(negedge clk);
    chk("rst_rdata", 192'(readdata), 192'(0));
    chk("rst_wait", 192'(waitrequest), 192'(0));
    chk("rst_strobe", 192'(commit_strobe_o), 192'(0));
    chk("rst_kp", 192'(kp_o), 192'({NM{16'h0001}}));
    chk("rst_ki", 192'(ki_o), 192'(0));
    chk("rst_pwm", 192'(pwmlimit_o), 192'({NM{24'h7FFFFF}}));
    chk("rst_int", 192'(intlimit_o), 192'({NM{24'h07A120}}));
    chk("rst_mode", 192'(control_mode_o), 192'({NM{8'h03}}));
    chk("rst_freq", 192'(update_frequency_Hz), 192'(100));
    reset = 1'b0;

    do_read(16'h0000, "id", 32'hB15B0002);
    do_read(16'h0103, "kp3", 32'h1);
    do_read(16'h0B07, "mode7", 32'h3);
    do_read(16'h0804, "pwm4", 32'h007FFFFF);
    do_read(16'h1F00, "commit_rd", 32'hDEADBEEF);
    do_read(16'h1D00, "err0", 32'h0);

    // Shadow write, then commit of motor 2
    do_write(16'h0102, 32'h0000FFFE);
    do_read(16'h0102, "kp2_sh", 32'hFFFFFFFE);
    chk("kp2_act_old", 192'(kp_o[47:32]), 192'(16'h0001));
    do_read(16'h1E00, "pend_4", 32'h4);
    do_write(16'h1F00, 32'h4);
    chk("kp2_act_new", 192'(kp_o[47:32]), 192'(16'hFFFE));
    chk("strobe_4", 192'(commit_strobe_o), 192'(8'h04));
    @(negedge clk);
    chk("strobe_off", 192'(commit_strobe_o), 192'(0));
    do_read(16'h1E00, "pend_0", 32'h0);

    // Partial commit of setpoints
    do_write(16'h0C00, 32'h00123456);
    do_write(16'h0C05, 32'hFF800000);
    do_write(16'h1F00, 32'h1);
    chk("sp0_act", 192'(setpoint_o[23:0]), 192'(24'h123456));
    chk("sp5_act_old", 192'(setpoint_o[143:120]), 192'(0));
    chk("strobe_1", 192'(commit_strobe_o), 192'(8'h01));
    do_read(16'h1E00, "pend_20", 32'h20);
    do_write(16'h1F00, 32'hFFFFFFFF);
    chk("sp5_act_new", 192'(setpoint_o[143:120]), 192'(24'h800000));
    chk("strobe_ff", 192'(commit_strobe_o), 192'(8'hFF));
    do_read(16'h0C05, "sp5_sh", 32'hFF800000);
    do_read(16'h1E00, "pend_clr", 32'h0);
    do_write(16'h1F00, 32'h0);
    chk("strobe_zero_mask", 192'(commit_strobe_o), 192'(0));

    // Illegal accesses
    do_write(16'h0108, 32'h5);
    do_read(16'h0109, "bad_motor_rd", 32'hDEADBEEF);
    do_write(16'h0000, 32'h1);
    do_read(16'h1D00, "err3", 32'h3);
    do_read(16'h0000, "id_kept", 32'hB15B0002);
    do_read(16'h1E00, "pend_none", 32'h0);
    do_read(16'h0500, "unmapped", 32'hDEADBEEF);
    do_read(16'h1D00, "err4", 32'h4);
    do_write(16'h1D00, 32'h0);
    do_read(16'h1D00, "err_clr", 32'h0);

    // Position sampling and held read
    position_i[95:72] = 24'h800001;
    do_read(16'h0403, "pos3", 32'hFF800001);
    done_cnt = 0;
    @(negedge clk);
    address = 16'h0403; read = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("held_wait%0d", i), 192'(waitrequest), 192'((i % 2) == 0));
      if (!waitrequest) begin
        done_cnt++;
        chk("held_data", 192'(readdata), 192'(32'hFF800001));
      end
      @(negedge clk);
    end
    read = 1'b0;
    chk("held_count", 192'(done_cnt), 192'(3));

    // Read and write together: read completes, write dropped, error counted
    @(negedge clk);
    address = 16'h0101; writedata = 32'h7; read = 1'b1; write = 1'b1;
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    #1 chk("rw_rdata", 192'(readdata), 192'(1));
    do_read(16'h0101, "rw_kp1", 32'h1);
    do_read(16'h1D00, "rw_err", 32'h1);

    do_write(16'h1100, 32'd1000);
    chk("freq", 192'(update_frequency_Hz), 192'(1000));
    do_write(16'h0B01, 32'h000001FF);
    do_read(16'h0B01, "mode1_sh", 32'h000000FF);

    // Reset during a read wait cycle
    @(negedge clk);
    address = 16'h0000; read = 1'b1;
    #1 chk("mid_wait1", 192'(waitrequest), 192'(1));
    #2 reset = 1'b1;
    #1 chk("mid_wait0", 192'(waitrequest), 192'(0));
    chk("mid_rdata", 192'(readdata), 192'(0));
    chk("mid_kp", 192'(kp_o), 192'({NM{16'h0001}}));
    chk("mid_sp", 192'(setpoint_o), 192'(0));
    chk("mid_mode", 192'(control_mode_o), 192'({NM{8'h03}}));
    chk("mid_freq", 192'(update_frequency_Hz), 192'(100));
    chk("mid_strobe", 192'(commit_strobe_o), 192'(0));
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_read(16'h0B01, "post_mode1", 32'h3);
    do_read(16'h1E00, "post_pend", 32'h0);
    do_read(16'h1D00, "post_err", 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
